// File: rtl/mc_control_unit.sv
// mc_control_unit -- multicycle MIPS control FSM.
//
// Sequences each instruction through fetch / decode / execute / memory /
// writeback, one state per cycle.  Memory states stall on mem_ready with a
// bounded wait; an overrun or an unsupported encoding lands in a sticky
// FAULT state that only reset clears.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op_code, funct        IR[31:26], IR[5:0]
//   zero                  ALU zero flag (gates PCWriteCond into pc_en)
//   mem_ready             memory completes the current access this cycle
//   PCWrite..PCSource     datapath control, decoded from the current state
//   pc_en                 PCWrite | (PCWriteCond & zero)
//   fault, timeout        sticky fault flag and its "memory timeout" cause
//   state                 current state encoding
module mc_control_unit #(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int MEM_WAIT_EN = 1,
  parameter int WAIT_W      = 4,
  parameter int MAX_WAIT    = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op_code,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               pc_en,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         RegDst,
  output logic               RegWrite,
  output logic               ALUsrcA,
  output logic [1:0]         ALUsrcB,
  output logic [1:0]         ALUop,
  output logic [1:0]         PCSource,
  output logic               fault,
  output logic               timeout,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2,  ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,  ST_MEMWR  = 4'd5,  ST_RTYPE  = 4'd6,  ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,  ST_ADDI   = 4'd9,  ST_ANDI   = 4'd10, ST_JAL    = 4'd11,
    ST_JR     = 4'd12, ST_UNUSED13 = 4'd13, ST_UNUSED14 = 4'd14, ST_FAULT = 4'd15
  } state_t;

  localparam logic [OP_W-1:0]    OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0]    OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0]    OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0]    OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0]    OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0]    OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0]    OP_JAL   = OP_W'(6'b000011);
  localparam logic [FUNCT_W-1:0] FN_JR    = FUNCT_W'(6'b001000);
  localparam logic [WAIT_W-1:0]  WAIT_LIM = WAIT_W'(MAX_WAIT);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                fault_q, fault_d;
  logic                timeout_q, timeout_d;
  logic                ready;
  logic                mem_state;

  // With the handshake disabled every access completes in one cycle.
  assign ready     = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign mem_state = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    case (state_q)
      ST_FETCH:  if (ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (op_code == OP_RTYPE)                        state_d = (funct == FN_JR) ? ST_JR : ST_RTYPE;
        else if (op_code == OP_LW || op_code == OP_SW)  state_d = ST_MEMADR;
        else if (op_code == OP_BEQ)                     state_d = ST_BRANCH;
        else if (op_code == OP_ADDI)                    state_d = ST_ADDI;
        else if (op_code == OP_ANDI)                    state_d = ST_ANDI;
        else if (op_code == OP_JAL)                     state_d = ST_JAL;
        else                                            state_d = ST_FAULT;
      end
      ST_MEMADR: state_d = (op_code == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (ready) state_d = ST_MEMWB;
      ST_MEMWR:  if (ready) state_d = ST_FETCH;
      ST_RTYPE, ST_ADDI, ST_ANDI:               state_d = ST_ALUWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JAL, ST_JR: state_d = ST_FETCH;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
    // A stall with the counter already at the limit is the overrun; a
    // completing access in that same cycle took the normal branch above.
    if (mem_state && !ready) begin
      if (wait_cnt_q == WAIT_LIM) begin
        state_d   = ST_FAULT;
        timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
    fault_d = fault_q | (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'b00;
    RegDst      = 2'b00;
    RegWrite    = 1'b0;
    ALUsrcA     = 1'b0;
    ALUsrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUsrcB = 2'b01;
        IRWrite = ready;
        PCWrite = ready;
      end
      ST_DECODE: ALUsrcB = 2'b11;
      ST_MEMADR: begin ALUsrcA = 1'b1; ALUsrcB = 2'b10; end
      ST_MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
      ST_MEMWB:  begin MemtoReg = 2'b01; RegWrite = 1'b1; end
      ST_MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
      ST_RTYPE:  begin ALUsrcA = 1'b1; ALUop = 2'b10; end
      ST_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = (op_code == OP_RTYPE) ? 2'b01 : 2'b00;
      end
      ST_BRANCH: begin
        ALUsrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      ST_ADDI:   begin ALUsrcA = 1'b1; ALUsrcB = 2'b10; end
      ST_ANDI:   begin ALUsrcA = 1'b1; ALUsrcB = 2'b10; ALUop = 2'b11; end
      ST_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
        RegWrite = 1'b1;
      end
      ST_JR:     begin PCWrite = 1'b1; PCSource = 2'b11; end
      default: ;
    endcase
    pc_en = PCWrite | (PCWriteCond & zero);
    // Reset kills every strobe immediately so no partial write survives.
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      pc_en       = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 2'b00;
      RegDst      = 2'b00;
      RegWrite    = 1'b0;
      ALUsrcA     = 1'b0;
      ALUsrcB     = 2'b00;
      ALUop       = 2'b00;
      PCSource    = 2'b00;
    end
  end

  assign fault   = fault_q;
  assign timeout = timeout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: directed literal sequences followed by
// randomized instruction streams, checked every cycle against a model that
// tracks each instruction as a list of states it must visit.
module tb_mc_control_unit;

  localparam int MAX_WAIT = 15;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_JR = 3, K_ADDI = 4,
                 K_ANDI = 5, K_BEQ = 6, K_JAL = 7, K_ILL = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op_code = 6'b0;
  logic [5:0] funct = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, RegDst, ALUsrcB, ALUop, PCSource;
  logic       RegWrite, ALUsrcA, fault, timeout;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_control_unit #(
    .OP_W(6), .FUNCT_W(6), .MEM_WAIT_EN(1), .WAIT_W(4), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUop(ALUop), .PCSource(PCSource),
    .fault(fault), .timeout(timeout), .state(state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: current state, which instruction is in flight and how far along.
  int m_state = 0;
  int m_kind = 0;
  int m_step = 0;
  int m_stall = 0;
  bit m_fault = 1'b0;
  bit m_timeout = 1'b0;

  // Literal expectations pinned by the directed phase.
  bit lit_en = 1'b0;
  int lit_state = 0;
  bit lit_fault = 1'b0;
  bit lit_to = 1'b0;

  function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? K_JR : K_R;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      6'b001100: return K_ANDI;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic string kname(int k);
    case (k)
      K_LW: return "lw";     K_SW: return "sw";     K_R: return "rtype";
      K_JR: return "jr";     K_ADDI: return "addi"; K_ANDI: return "andi";
      K_BEQ: return "beq";   K_JAL: return "jal";   default: return "illegal";
    endcase
  endfunction

  // States visited after FETCH, in order; 0 means back to FETCH.
  function automatic int plan_at(int k, int i);
    int seq [5];
    case (k)
      K_LW:   seq = '{1, 2, 3, 4, 0};
      K_SW:   seq = '{1, 2, 5, 0, 0};
      K_R:    seq = '{1, 6, 7, 0, 0};
      K_ADDI: seq = '{1, 9, 7, 0, 0};
      K_ANDI: seq = '{1, 10, 7, 0, 0};
      K_BEQ:  seq = '{1, 8, 0, 0, 0};
      K_JAL:  seq = '{1, 11, 0, 0, 0};
      K_JR:   seq = '{1, 12, 0, 0, 0};
      default: seq = '{1, 15, 15, 15, 15};
    endcase
    return (i >= 0 && i < 5) ? seq[i] : 0;
  endfunction

  // Control word a state must present:
  // {PCWrite,PCWriteCond,pc_en,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUsrcA,ALUsrcB,ALUop,PCSource}
  function automatic logic [18:0] exp_ctrl(int st, logic rdy, logic z, logic [5:0] op);
    logic pcw = 1'b0, pcc = 1'b0, iord = 1'b0, mr = 1'b0, mw = 1'b0, irw = 1'b0;
    logic rw = 1'b0, asa = 1'b0;
    logic [1:0] m2r = 2'b00, rd = 2'b00, asb = 2'b00, aop = 2'b00, pcs = 2'b00;
    case (st)
      0:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mr = 1'b1; iord = 1'b1; end
      4:  begin m2r = 2'b01; rw = 1'b1; end
      5:  begin mw = 1'b1; iord = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rd = (op == 6'b000000) ? 2'b01 : 2'b00; end
      8:  begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; pcs = 2'b01; end
      9:  begin asa = 1'b1; asb = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
      11: begin pcw = 1'b1; pcs = 2'b10; rd = 2'b10; m2r = 2'b10; rw = 1'b1; end
      12: begin pcw = 1'b1; pcs = 2'b11; end
      default: ;
    endcase
    return {pcw, pcc, pcw | (pcc & z), iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
  endfunction

  // Model update on each rising edge, using the inputs held over the cycle.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_state = 0; m_kind = 0; m_step = 0; m_stall = 0;
      m_fault = 1'b0; m_timeout = 1'b0;
    end else if (m_state == 15) begin
      // sticky until reset
    end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
      m_stall = m_stall + 1;
      if (m_stall > MAX_WAIT) begin
        m_state = 15; m_fault = 1'b1; m_timeout = 1'b1;
        $display("[%0t] timeout after %0d stalled cycles", $time, m_stall);
      end
    end else begin
      m_stall = 0;
      if (m_state == 0) begin
        m_kind = kind_of(op_code, funct);
        m_step = 1;
        m_state = 1;
      end else begin
        m_state = plan_at(m_kind, m_step);
        m_step = m_step + 1;
        if (m_state == 15) begin
          m_fault = 1'b1;
          $display("[%0t] illegal op=%b funct=%b -> fault", $time, op_code, funct);
        end else if (m_state == 0) begin
          $display("[%0t] retired %s", $time, kname(m_kind));
        end
      end
    end
  end

  // Single compare process, on the falling edge.
  initial forever begin
    logic [24:0] act_v, exp_v;
    @(negedge clk);
    act_v = {PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUsrcA, ALUsrcB, ALUop, PCSource,
             fault, timeout, state};
    if (!rst_n) exp_v = '0;
    else exp_v = {exp_ctrl(m_state, mem_ready, zero, op_code), m_fault, m_timeout, 4'(m_state)};
    n_cmp = n_cmp + 1;
    if (act_v !== exp_v) begin
      n_bad = n_bad + 1;
      $display("FAIL ctrl t=%0t got=%b expected=%b", $time, act_v, exp_v);
    end
    if (lit_en) begin
      n_cmp = n_cmp + 1;
      if ({state, fault, timeout} !== {4'(lit_state), lit_fault, lit_to}) begin
        n_bad = n_bad + 1;
        $display("FAIL literal t=%0t got state=%0d fault=%b timeout=%b expected state=%0d fault=%b timeout=%b",
                 $time, state, fault, timeout, lit_state, lit_fault, lit_to);
      end
    end
  end

  task automatic step(input logic rn, input logic rdy, input logic [5:0] op,
                      input int ls, input logic lf, input logic lt);
    @(posedge clk);
    #1;
    rst_n = rn; mem_ready = rdy; op_code = op; funct = 6'b100000; zero = 1'b0;
    lit_en = 1'b1; lit_state = ls; lit_fault = lf; lit_to = lt;
  endtask

  initial begin
    logic [5:0] rfn [5];
    logic [5:0] ill [4];
    int stall_left;
    int fault_cyc;
    rfn = '{6'b100000, 6'b100100, 6'b100111, 6'b101010, 6'b000000};
    ill = '{6'b111111, 6'b000010, 6'b001101, 6'b100000};
    stall_left = 0;
    fault_cyc = 0;

    // Zero-wait lw: 0,1,2,3,4,0
    step(1'b0, 1'b1, 6'b100011, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 4, 1'b0, 1'b0);
    // Illegal opcode traps and holds for 20 cycles.
    step(1'b1, 1'b1, 6'b111111, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'b111111, 1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'b111111, 15, 1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b0, 6'b111111, 15, 1'b1, 1'b0);
    // Reset, then 16 stalled fetch cycles -> timeout fault.
    step(1'b0, 1'b1, 6'b100011, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6'b100011, 0, 1'b0, 1'b0);
    repeat (15) step(1'b1, 1'b0, 6'b100011, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6'b100011, 15, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 6'b100011, 15, 1'b1, 1'b1);
    // Same, but memory answers on the 16th cycle: completion wins.
    step(1'b0, 1'b0, 6'b100011, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6'b100011, 0, 1'b0, 1'b0);
    repeat (14) step(1'b1, 1'b0, 6'b100011, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 1, 1'b0, 1'b0);

    // Randomized instruction stream.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      lit_en = 1'b0;
      fault_cyc = m_fault ? fault_cyc + 1 : 0;
      if (!rst_n) rst_n = 1'b1;
      else if (fault_cyc >= 22 || $urandom_range(0, 299) == 0) rst_n = 1'b0;

      if (m_state == 0) begin
        case ($urandom_range(0, 12))
          0, 1, 2: begin op_code = 6'b000000; funct = rfn[$urandom_range(0, 4)]; end
          3:       begin op_code = 6'b000000; funct = 6'b001000; end
          4, 5:    op_code = 6'b100011;
          6, 7:    op_code = 6'b101011;
          8:       op_code = 6'b000100;
          9:       op_code = 6'b001000;
          10:      op_code = 6'b001100;
          11:      op_code = 6'b000011;
          default: op_code = ($urandom_range(0, 2) == 0) ? ill[$urandom_range(0, 3)] : 6'b100011;
        endcase
        if (op_code != 6'b000000) funct = 6'($urandom_range(0, 63));
      end

      if (stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left = stall_left - 1;
      end else if ($urandom_range(0, 59) == 0) begin
        mem_ready = 1'b0;
        stall_left = $urandom_range(13, 16);
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
      end
      zero = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
